// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, register select codes and STATUS bit
// positions for the memory-mapped UART, shared with software and the bench.
// Offsets are byte offsets inside the 16-byte window; select = offset[3:2].
package uart_mmio_pkg;

  localparam logic [3:0] STATUS_OFS = 4'h0;
  localparam logic [3:0] RXDATA_OFS = 4'h4;
  localparam logic [3:0] TXDATA_OFS = 4'h8;
  localparam logic [3:0] CYCLE_OFS  = 4'hC;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FREE  = 1;
  localparam int ST_RX_OVF   = 2;
  localparam int ST_TX_OVR   = 3;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_RXDATA = 2'd1,
    REG_TXDATA = 2'd2,
    REG_CYCLE  = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational (read-first) head.
// Latency: a push at edge N is visible on head/empty after edge N.
// Backpressure: push while full is ignored unless a pop happens in the same
// cycle, in which case both are performed and count is unchanged.
// Ports: clk, reset (sync, active-high), push/push_data, pop, head, full,
// empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle;
  // head already presented the old byte, so the overwrite is safe.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: bus-side register block for the UART (STATUS, RX FIFO, TX
// holding register, free-running cycle counter).
// Latency: reads return on o_rdata one cycle after i_re; writes act at the strobe edge.
// Backpressure: rx_ready tied high (overflow is flagged, not stalled);
// tx holds one byte, extra writes are dropped and flagged.
// Ports: clk/reset, bus (i_addr, i_wdata, i_we, i_re, o_rdata),
// uart TX side (tx_data, tx_valid, tx_ready), RX side (rx_data, rx_valid, rx_ready).
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int              RX_DEPTH  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_we,
  input  logic            i_re,
  output logic [XLEN-1:0] o_rdata,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready
);

  logic                      hit;
  reg_sel_e                  sel;
  logic                      wr;
  logic                      rd;
  logic                      rx_pop;
  logic                      rx_drop;
  logic                      tx_hs;
  logic                      tx_load;
  logic                      tx_reject;
  logic                      clr_rx_ovf;
  logic                      clr_tx_ovr;
  logic                      rx_ovf;
  logic                      tx_ovr;
  logic [XLEN-1:0]           cycle_cnt;
  logic [XLEN-1:0]           rd_mux;
  logic [7:0]                fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(RX_DEPTH):0] unused_rx_count;
  logic                      unused_bits;

  assign unused_bits = ^{i_addr[1:0], i_wdata[XLEN-1:8], i_wdata[1:0], i_wdata[7:4]};

  assign hit = (i_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign sel = reg_sel_e'(i_addr[3:2]);
  assign wr  = hit && i_we;
  // A read issued together with a write is squashed: no pop, data 0.
  assign rd  = hit && i_re && !i_we;

  // RX path
  assign rx_ready = 1'b1;
  assign rx_pop   = rd && (sel == REG_RXDATA) && !fifo_empty;
  assign rx_drop  = rx_valid && fifo_full && !rx_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_rx_count)
  );

  // TX path: a write in the handshake cycle sees the register as free.
  assign tx_hs     = tx_valid && tx_ready;
  assign tx_load   = wr && (sel == REG_TXDATA) && (!tx_valid || tx_hs);
  assign tx_reject = wr && (sel == REG_TXDATA) && tx_valid && !tx_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (tx_load) begin
      tx_valid <= 1'b1;
      tx_data  <= i_wdata[7:0];
    end else if (tx_hs) begin
      tx_valid <= 1'b0;
    end
  end

  // Sticky flags: set has priority over a software clear in the same cycle.
  assign clr_rx_ovf = wr && (sel == REG_STATUS) && i_wdata[ST_RX_OVF];
  assign clr_tx_ovr = wr && (sel == REG_STATUS) && i_wdata[ST_TX_OVR];

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf <= 1'b0;
      tx_ovr <= 1'b0;
    end else begin
      if (rx_drop)         rx_ovf <= 1'b1;
      else if (clr_rx_ovf) rx_ovf <= 1'b0;
      if (tx_reject)       tx_ovr <= 1'b1;
      else if (clr_tx_ovr) tx_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                           cycle_cnt <= '0;
    else if (wr && (sel == REG_CYCLE))   cycle_cnt <= '0;
    else                                 cycle_cnt <= cycle_cnt + XLEN'(1);
  end

  // Read mux uses pre-edge state, so CYCLE reads the value before this
  // edge's increment and STATUS reflects writes from earlier cycles only.
  always_comb begin
    rd_mux = '0;
    unique case (sel)
      REG_STATUS: begin
        rd_mux[ST_RX_AVAIL] = !fifo_empty;
        rd_mux[ST_TX_FREE]  = !tx_valid;
        rd_mux[ST_RX_OVF]   = rx_ovf;
        rd_mux[ST_TX_OVR]   = tx_ovr;
      end
      REG_RXDATA: if (!fifo_empty) rd_mux[7:0] = fifo_head;
      REG_TXDATA: rd_mux = '0;
      REG_CYCLE:  rd_mux = cycle_cnt;
      default:    rd_mux = '0;
    endcase
  end

  // Every read strobe updates o_rdata; misses and squashed reads return 0.
  always_ff @(posedge clk) begin
    if (reset)     o_rdata <= '0;
    else if (i_re) o_rdata <= rd ? rd_mux : '0;
  end

endmodule

// File: tb/tb_uart_mmio.sv
module tb_uart_mmio;
  import uart_mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr, i_wdata, o_rdata;
  logic        i_we, i_re;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  tx_q[$];

  uart_mmio #(.XLEN(32), .BASE_ADDR(BASE), .RX_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_we(i_we), .i_re(i_re), .o_rdata(o_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: inputs driven at negedge, sampled at the next posedge.
  // Reads enqueue their expected value; it is dequeued once o_rdata is valid.
  task automatic op(input logic we, input logic re, input logic [3:0] ofs,
                    input logic [31:0] wd, input logic rxv, input logic [7:0] rxd,
                    input logic [31:0] exp, input string tag, input logic miss = 1'b0);
    @(negedge clk);
    i_we = we; i_re = re; i_wdata = wd;
    i_addr = (miss ? (BASE ^ 32'h0000_0100) : BASE) | {28'h0, ofs};
    rx_valid = rxv; rx_data = rxd;
    if (re) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clk); #1;
    i_we = 1'b0; i_re = 1'b0; rx_valid = 1'b0;
    if (re) check(tag_q.pop_front(), o_rdata, exp_q.pop_front());
  endtask

  task automatic rd(input logic [3:0] ofs, input logic [31:0] exp, input string tag);
    op(1'b0, 1'b1, ofs, 32'h0, 1'b0, 8'h0, exp, tag);
  endtask

  task automatic wr(input logic [3:0] ofs, input logic [31:0] wd);
    op(1'b1, 1'b0, ofs, wd, 1'b0, 8'h0, 32'h0, "wr");
  endtask

  task automatic rx_push(input logic [7:0] b);
    op(1'b0, 1'b0, STATUS_OFS, 32'h0, 1'b1, b, 32'h0, "push");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // TX monitor: sampled mid-low-phase, when inputs for the next edge are stable.
  always begin
    @(negedge clk); #2;
    if (!reset && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_addr = '0; i_wdata = '0; i_we = 1'b0; i_re = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    idle(3);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    @(negedge clk); reset = 1'b0;
    idle(2);
    rd(CYCLE_OFS, 32'd2, "cycle_after_reset");
    rd(STATUS_OFS, 32'h2, "status_reset");
    op(1'b0, 1'b1, STATUS_OFS, 32'h0, 1'b0, 8'h0, 32'h0, "miss_read", 1'b1);

    // Write+read together: write clears counter, read squashed.
    op(1'b1, 1'b1, CYCLE_OFS, 32'h1234, 1'b0, 8'h0, 32'h0, "we_re_read");
    rd(CYCLE_OFS, 32'd0, "cycle_after_clear");
    rd(CYCLE_OFS, 32'd1, "cycle_increment");

    // TX holding register overrun
    wr(TXDATA_OFS, 32'h41);
    idle(5);
    check("tx_valid_held", {31'h0, tx_valid}, 32'h1);
    check("tx_data_held", {24'h0, tx_data}, 32'h41);
    wr(TXDATA_OFS, 32'h42);
    check("tx_data_kept", {24'h0, tx_data}, 32'h41);
    rd(STATUS_OFS, 32'h8, "status_tx_ovr");
    rd(TXDATA_OFS, 32'h0, "txdata_read_zero");
    tx_q.push_back(8'h41);
    @(negedge clk); tx_ready = 1'b1;
    @(posedge clk); #1;
    check("tx_valid_drop", {31'h0, tx_valid}, 32'h0);
    wr(STATUS_OFS, 32'h8);
    rd(STATUS_OFS, 32'h2, "status_tx_ovr_clr");

    // RX overflow and in-order drain
    for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
    rd(STATUS_OFS, 32'h7, "status_rx_full_ovf");
    for (int i = 0; i < 8; i++) rd(RXDATA_OFS, 32'h10 + i, "rx_drain");
    rd(RXDATA_OFS, 32'h0, "rx_empty_read");
    rd(STATUS_OFS, 32'h6, "status_rx_empty");
    wr(STATUS_OFS, 32'h4);
    rd(STATUS_OFS, 32'h2, "status_rx_ovf_clr");

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 8; i++) rx_push(8'h20 + 8'(i));
    op(1'b0, 1'b1, RXDATA_OFS, 32'h0, 1'b1, 8'h99, 32'h20, "rx_pop_push_full");
    rd(STATUS_OFS, 32'h3, "status_no_ovf");
    for (int i = 1; i < 8; i++) rd(RXDATA_OFS, 32'h20 + i, "rx_drain2");
    rd(RXDATA_OFS, 32'h99, "rx_last_99");
    rd(STATUS_OFS, 32'h2, "status_drained");

    // TX write in the handshake cycle
    tx_ready = 1'b0;
    wr(TXDATA_OFS, 32'h54);
    tx_q.push_back(8'h54);
    tx_q.push_back(8'h55);
    tx_ready = 1'b1;
    wr(TXDATA_OFS, 32'h55);
    check("tx_refill_data", {24'h0, tx_data}, 32'h55);
    check("tx_refill_valid", {31'h0, tx_valid}, 32'h1);
    idle(1);
    tx_ready = 1'b0;
    rd(STATUS_OFS, 32'h2, "status_tx_refill");

    // Sticky set wins over clear in the same cycle
    for (int i = 0; i < 8; i++) rx_push(8'h30 + 8'(i));
    wr(TXDATA_OFS, 32'h60);
    wr(TXDATA_OFS, 32'h61);
    op(1'b1, 1'b0, STATUS_OFS, 32'hC, 1'b1, 8'h38, 32'h0, "wr");
    rd(STATUS_OFS, 32'h5, "status_set_wins");
    tx_q.push_back(8'h60);
    tx_ready = 1'b1;
    idle(2);
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) rd(RXDATA_OFS, 32'h30 + i, "rx_drain3");

    // Reset mid-transfer
    wr(TXDATA_OFS, 32'h70);
    rx_push(8'h71);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_mid_tx_data", {24'h0, tx_data}, 32'h0);
    @(negedge clk); reset = 1'b0;
    rd(STATUS_OFS, 32'h2, "status_after_mid_reset");

    idle(2);
    check("tx_queue_empty", tx_q.size(), 32'd0);
    check("rd_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
